// File: rtl/button_conditioner.sv
// button_conditioner: four independent push-button conditioners.
// Each raw button level is synchronized, debounced by a small FSM and
// turned into a debounced level plus a single-cycle press pulse.
// Optional feature: define BTN_AUTO_REPEAT_EN to compile in hold-to-repeat
// pulses (first after REPEAT_DELAY cycles, then every REPEAT_RATE cycles).
//
// Handshake: none; pulse outputs are fire-and-forget, high for exactly one
// clk cycle, and the consumer must sample them every cycle.
// dbg_state exposes the four FSM states, two bits per button, in the same
// {exit, change, select, confirm} order as btn_level.
module button_conditioner #(
   parameter int DEB_CYCLES   = 2000000,
   parameter int REPEAT_DELAY = 50000000,
   parameter int REPEAT_RATE  = 10000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       confirm_raw,
   input  logic       select_raw,
   input  logic       change_raw,
   input  logic       exit_raw,
   output logic       confirm,
   output logic       select,
   output logic       change,
   output logic       exit,
   output logic [3:0] btn_level,
   output logic       any_pulse,
   output logic [7:0] dbg_state
);

   // Counter width covers the largest of the three cycle counts.
   localparam int MAX_AB = (DEB_CYCLES > REPEAT_DELAY) ? DEB_CYCLES : REPEAT_DELAY;
   localparam int MAX_C  = (MAX_AB > REPEAT_RATE) ? MAX_AB : REPEAT_RATE;
   localparam int CW     = $clog2(MAX_C + 1);

   // The press/release decision is taken when the incremented count hits
   // this value, which gives DEB_CYCLES stable samples including the IDLE one.
   localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
`ifdef BTN_AUTO_REPEAT_EN
   localparam logic [CW-1:0] DELAY_T  = CW'(REPEAT_DELAY);
   localparam logic [CW-1:0] RATE_T   = CW'(REPEAT_RATE);
`endif

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   logic [3:0] raw;
   logic [3:0] sync1;
   logic [3:0] s;
   logic [3:0] fire_v;
   logic [3:0] pulse_v;
   logic [3:0] level_v;

   assign raw = {exit_raw, change_raw, select_raw, confirm_raw};

   // Two-flop synchronizer for all four raw inputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= '0;
         s     <= '0;
      end else begin
         sync1 <= raw;
         s     <= sync1;
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_btn
      state_t        state;
      logic [CW-1:0] cnt;
      logic [CW-1:0] cnt_inc;
      logic          press_fire;
      logic          rep_fire;
      logic          pulse_r;
      logic          level_r;

      // Saturating increment: the counter never wraps back to zero.
      assign cnt_inc    = (cnt == '1) ? cnt : cnt + CW'(1);
      assign press_fire = (state == PRESS_WAIT) && s[i] && (cnt_inc == DEB_LAST);

`ifdef BTN_AUTO_REPEAT_EN
      logic [CW-1:0] hold;
      logic [CW-1:0] hold_inc;
      logic          rep_armed;

      // Hold counter only advances while PRESSED with the button still down,
      // so a bounce through RELEASE_WAIT freezes it without re-arming.
      assign hold_inc = (hold == '1) ? hold : hold + CW'(1);
      assign rep_fire = (state == PRESSED) && s[i] &&
                        (hold_inc == (rep_armed ? RATE_T : DELAY_T));
`else
      assign rep_fire = 1'b0;
`endif

      assign fire_v[i]           = press_fire | rep_fire;
      assign pulse_v[i]          = pulse_r;
      assign level_v[i]          = level_r;
      assign dbg_state[2*i +: 2] = state;

      // Per-button debounce FSM with registered pulse and level outputs.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            pulse_r   <= 1'b0;
            level_r   <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            hold      <= '0;
            rep_armed <= 1'b0;
`endif
         end else begin
            pulse_r <= fire_v[i];
            case (state)
               IDLE: begin
                  if (s[i]) begin
                     state <= PRESS_WAIT;
                     cnt   <= '0;
                  end
               end
               PRESS_WAIT: begin
                  if (!s[i]) begin
                     state <= IDLE;
                  end else if (press_fire) begin
                     state     <= PRESSED;
                     level_r   <= 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
                     hold      <= '0;
                     rep_armed <= 1'b0;
`endif
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
               PRESSED: begin
                  if (!s[i]) begin
                     state <= RELEASE_WAIT;
                     cnt   <= '0;
                  end
`ifdef BTN_AUTO_REPEAT_EN
                  else if (rep_fire) begin
                     hold      <= '0;
                     rep_armed <= 1'b1;
                  end else begin
                     hold <= hold_inc;
                  end
`endif
               end
               RELEASE_WAIT: begin
                  if (s[i]) begin
                     state <= PRESSED;
                  end else if (cnt_inc == DEB_LAST) begin
                     state   <= IDLE;
                     level_r <= 1'b0;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // any_pulse is registered in the same cycle as the individual pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) any_pulse <= 1'b0;
      else        any_pulse <= |fire_v;
   end

   assign confirm   = pulse_v[0];
   assign select    = pulse_v[1];
   assign change    = pulse_v[2];
   assign exit      = pulse_v[3];
   assign btn_level = level_v;

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed scenarios for button_conditioner with a
// pulse scoreboard. Expected pulses are queued as {cycle, pulse vector}
// when a press is driven and popped whenever the DUT pulses.
module tb_button_conditioner;
   localparam int DEB = 8;
   localparam int RD  = 40;
   localparam int RR  = 10;
   localparam int W   = 28;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       confirm_raw, select_raw, change_raw, exit_raw;
   logic       confirm, select, change, exit;
   logic [3:0] btn_level;
   logic       any_pulse;
   logic [7:0] dbg_state;

   button_conditioner #(
      .DEB_CYCLES  (DEB),
      .REPEAT_DELAY(RD),
      .REPEAT_RATE (RR)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .confirm_raw(confirm_raw),
      .select_raw (select_raw),
      .change_raw (change_raw),
      .exit_raw   (exit_raw),
      .confirm    (confirm),
      .select     (select),
      .change     (change),
      .exit       (exit),
      .btn_level  (btn_level),
      .any_pulse  (any_pulse),
      .dbg_state  (dbg_state)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   int           n_cmp = 0;
   int           n_bad = 0;
   logic [W-1:0] exp_q[$];
   logic [3:0]   mon_v;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic expect_pulse(input int at, input logic [3:0] v);
      logic [23:0] at24;
      at24 = at[23:0];
      exp_q.push_back({at24, v});
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_level"}, btn_level, 4'b0000);
      check({tag, "_pulses"}, {exit, change, select, confirm}, 4'b0000);
      check({tag, "_any"}, any_pulse, 1'b0);
      check({tag, "_state"}, dbg_state, 8'h00);
   endtask

   // Monitor: every observed pulse must match the head of the queue.
   always @(negedge clk) begin
      mon_v = {exit, change, select, confirm};
      if (mon_v != 4'b0000 || any_pulse) begin
         check("any_pulse_or", any_pulse, |mon_v);
         if (mon_v != 4'b0000) begin
            if (exp_q.size() == 0) check("unexpected_pulse", {cyc[23:0], mon_v}, 0);
            else                   check("pulse", {cyc[23:0], mon_v}, exp_q.pop_front());
         end
      end
   end

   // ---------------- stimulus ----------------
   int c0, c1, cr, gap;

   initial begin
      reset       = 1'b0;
      confirm_raw = 1'b0;
      select_raw  = 1'b0;
      change_raw  = 1'b0;
      exit_raw    = 1'b0;
      idle(3);
      check_all_zero("reset");
      reset = 1'b1;
      idle(3);

      // Single press held 30 cycles: pulse 10 edges after first high sample.
      c0 = cyc;
      confirm_raw = 1'b1;
      expect_pulse(c0 + 10, 4'b0001);
      idle(9);
      check("s1_level_before", btn_level, 4'b0000);
      idle(1);
      check("s1_level_after", btn_level, 4'b0001);
      idle(20);
      c1 = cyc;
      confirm_raw = 1'b0;
      idle(9);
      check("s1_level_rel_before", btn_level, 4'b0001);
      idle(1);
      check("s1_level_rel_after", btn_level, 4'b0000);
      idle(5);

      // Glitchy select: 5 high, 3 low, 5 high -> never accepted.
      select_raw = 1'b1;
      idle(5);
      select_raw = 1'b0;
      idle(3);
      select_raw = 1'b1;
      idle(5);
      check("s2_level_mid", btn_level, 4'b0000);
      select_raw = 1'b0;
      idle(15);
      check("s2_level_end", btn_level, 4'b0000);

      // Simultaneous change and exit press.
      c0 = cyc;
      change_raw = 1'b1;
      exit_raw   = 1'b1;
      expect_pulse(c0 + 10, 4'b1100);
      idle(10);
      check("s3_any_on", any_pulse, 1'b1);
      check("s3_level", btn_level, 4'b1100);
      idle(1);
      check("s3_any_off", any_pulse, 1'b0);
      idle(9);
      change_raw = 1'b0;
      exit_raw   = 1'b0;
      idle(12);
      check("s3_level_end", btn_level, 4'b0000);

      // Reset in the middle of PRESS_WAIT, button still held on release.
      c0 = cyc;
      confirm_raw = 1'b1;
      idle(8);
      reset = 1'b0;
      idle(1);
      check_all_zero("s4_in_reset");
      idle(2);
      reset = 1'b1;
      cr = cyc;
      expect_pulse(cr + 10, 4'b0001);
      idle(9);
      check("s4_level_before", btn_level, 4'b0000);
      idle(1);
      check("s4_level_after", btn_level, 4'b0001);
      idle(5);
      confirm_raw = 1'b0;
      idle(12);
      check("s4_level_end", btn_level, 4'b0000);

      // Select held 100 cycles: one pulse, or auto-repeat if compiled in.
      c0 = cyc;
      select_raw = 1'b1;
      expect_pulse(c0 + 10, 4'b0010);
`ifdef BTN_AUTO_REPEAT_EN
      for (int k = 0; k < 6; k++) expect_pulse(c0 + 10 + RD + k * RR, 4'b0010);
`endif
      idle(30);
      check("s5_level_held", btn_level, 4'b0010);
      idle(70);
      select_raw = 1'b0;
      idle(12);
      check("s5_level_end", btn_level, 4'b0000);

      // Exit held with a 4-cycle low bounce: no second pulse, level stays.
      c0 = cyc;
      exit_raw = 1'b1;
      expect_pulse(c0 + 10, 4'b1000);
      idle(15);
      exit_raw = 1'b0;
      gap = 4;
      idle(gap);
      exit_raw = 1'b1;
      idle(3);
      check("s6_level_bounce", btn_level, 4'b1000);
      idle(7);
      check("s6_level_after", btn_level, 4'b1000);
      exit_raw = 1'b0;
      idle(12);
      check("s6_level_end", btn_level, 4'b0000);

      idle(5);
      check("exp_q_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
